// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: sync, clock glitch filter, start/8 data/parity/stop deserializer with watchdog.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 7500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    state_t         state, state_n;
    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_f, clk_f_d;
    logic [FCW-1:0] fcnt;
    logic [WDW-1:0] wd;
    logic [7:0]     shift_q;
    logic [2:0]     bit_cnt;
    logic           fall, timeout, parity_ok;
    logic           start_frame, shift_en, good, bad;

    // Pins idle high, so the synchronizers reset to 1 to avoid a spurious fall after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            fcnt    <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s2 == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
                clk_f <= clk_s2;
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + FCW'(1);
            end
        end
    end

    assign fall    = clk_f_d & ~clk_f;
    assign busy    = (state != IDLE);
    // A fall in the same cycle as the deadline wins, so timeout excludes it.
    assign timeout = busy && !fall && (wd == WDW'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     par_bit <= 1'b0;
        else if (state == PARITY && fall) par_bit <= dat_s2;
    end
    assign parity_ok = ^{shift_q, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        good        = 1'b0;
        bad         = 1'b0;
        case (state)
            IDLE: if (fall) begin
                if (!dat_s2) begin
                    state_n     = SHIFT;
                    start_frame = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            SHIFT: if (fall) begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd7) state_n = PARITY;
            end
            PARITY: if (fall) state_n = STOP;
            STOP: if (fall) begin
                state_n = IDLE;
                if (dat_s2 && parity_ok) good = 1'b1;
                else                     bad  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n = IDLE;
            bad     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd        <= '0;
            shift_q   <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == IDLE || fall) wd <= '0;
            else                       wd <= wd + WDW'(1);
            if (start_frame)   bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shift_q <= {dat_s2, shift_q[7:1]};
            if (good) rx_data <= shift_q;
            rx_valid  <= good;
            frame_err <= bad;
        end
    end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_ps2_frame_rx;
    localparam int LAT     = 11;
    localparam int TIMEOUT = 7500;

    logic       clk, rst_n, ps2_clk, ps2_data;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         err_seen = 0;
    bit         both_seen = 0;
    logic [7:0] last_good = 8'h00;

    ps2_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) got_q.push_back(rx_data);
            if (frame_err) err_seen++;
            if (rx_valid && frame_err) both_seen = 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // A frame is accepted when stop is 1 and, with checking on, the nine bits hold an odd count of ones.
    function automatic bit frame_ok(input logic [7:0] d, input bit par, input bit stop);
        bit ok = stop;
`ifdef PS2_PARITY_CHECK_EN
        ok = ok && ((($countones(d) + int'(par)) % 2) == 1);
`endif
        return ok;
    endfunction

    task automatic clear_obs();
        got_q.delete();
        err_seen = 0;
    endtask

    task automatic send_bit(input bit b, input int half, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            cyc(half - 15);
            ps2_clk = 1'b0;
            cyc(5);
            ps2_clk = 1'b1;
            cyc(10);
        end else begin
            cyc(half);
        end
        ps2_clk = 1'b0;
        cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int half, input bit glitch);
        send_bit(1'b0, half, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], half, glitch);
        send_bit(par, half, glitch);
        send_bit(stop, half, glitch);
        ps2_data = 1'b1;
        cyc(20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        cyc(5);
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %0h want 00", rx_data); end
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %0b want 0", rx_valid); end
        tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        cyc(20);
    endtask

    task automatic test_basic();
        clear_obs();
        send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b0);
        last_good = 8'h1C;
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL basic_count: got %0d want 1", got_q.size()); end
        tests_run++; if (rx_data !== 8'h1C) begin tests_failed++; $display("FAIL basic_data: got %0h want 1c", rx_data); end
        tests_run++; if (err_seen != 0) begin tests_failed++; $display("FAIL basic_err: got %0d want 0", err_seen); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_bit(1'b0, 30, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'hF0 >> i, 30, 1'b0);
        send_bit(1'b1, 30, 1'b0);
        send_bit(1'b1, 30, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 30, 1'b0);
        last_good = 8'h1C;
        tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
        tests_run++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'hF0) begin tests_failed++; $display("FAIL b2b_first: got %0h want f0", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
        tests_run++; if (((got_q.size() > 1) ? got_q[1] : 8'hxx) !== 8'h1C) begin tests_failed++; $display("FAIL b2b_second: got %0h want 1c", (got_q.size() > 1) ? got_q[1] : 8'hxx); end
        tests_run++; if (err_seen != 0) begin tests_failed++; $display("FAIL b2b_err: got %0d want 0", err_seen); end
    endtask

    task automatic test_parity_err();
        bit ok;
        clear_obs();
        send_frame(8'h29, odd_par(8'h29), 1'b1, 35, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1, 35, 1'b0);
        ok = frame_ok(8'h1C, 1'b1, 1'b1);
        last_good = ok ? 8'h1C : 8'h29;
        tests_run++; if (got_q.size() != (ok ? 2 : 1)) begin tests_failed++; $display("FAIL parity_count: got %0d want %0d", got_q.size(), ok ? 2 : 1); end
        tests_run++; if (err_seen != (ok ? 0 : 1)) begin tests_failed++; $display("FAIL parity_err: got %0d want %0d", err_seen, ok ? 0 : 1); end
        tests_run++; if (rx_data !== last_good) begin tests_failed++; $display("FAIL parity_data: got %0h want %0h", rx_data, last_good); end
    endtask

    task automatic test_stop_err();
        clear_obs();
        send_frame(8'h55, odd_par(8'h55), 1'b1, 25, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 25, 1'b0);
        last_good = 8'h55;
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL stop_count: got %0d want 1", got_q.size()); end
        tests_run++; if (err_seen != 1) begin tests_failed++; $display("FAIL stop_err: got %0d want 1", err_seen); end
        tests_run++; if (rx_data !== 8'h55) begin tests_failed++; $display("FAIL stop_data: got %0h want 55", rx_data); end
    endtask

    task automatic test_bad_start();
        clear_obs();
        send_bit(1'b1, 30, 1'b0);
        cyc(20);
        tests_run++; if (err_seen != 1) begin tests_failed++; $display("FAIL start_err: got %0d want 1", err_seen); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL start_busy: got %0b want 0", busy); end
    endtask

    task automatic test_timeout();
        int first = 0;
        logic busy_before = 1'bx;
        logic busy_after = 1'bx;
        clear_obs();
        send_bit(1'b0, 30, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 30, 1'b0);
        ps2_data = 1'b0;
        cyc(30);
        ps2_clk = 1'b0;
        for (int c = 1; c <= LAT + TIMEOUT + 60; c++) begin
            cyc(1);
            if (c == 30) ps2_clk = 1'b1;
            if (c == LAT + TIMEOUT - 1) busy_before = busy;
            if (frame_err === 1'b1 && first == 0) begin
                first = c;
                busy_after = busy;
            end
        end
        ps2_data = 1'b1;
        tests_run++; if (first != LAT + TIMEOUT) begin tests_failed++; $display("FAIL timeout_cycle: got %0d want %0d", first, LAT + TIMEOUT); end
        tests_run++; if (busy_before !== 1'b1) begin tests_failed++; $display("FAIL timeout_busy_before: got %0b want 1", busy_before); end
        tests_run++; if (busy_after !== 1'b0) begin tests_failed++; $display("FAIL timeout_busy_after: got %0b want 0", busy_after); end
        tests_run++; if (err_seen != 1) begin tests_failed++; $display("FAIL timeout_err_count: got %0d want 1", err_seen); end
        tests_run++; if (rx_data !== last_good) begin tests_failed++; $display("FAIL timeout_hold: got %0h want %0h", rx_data, last_good); end
        clear_obs();
        send_frame(8'h29, odd_par(8'h29), 1'b1, 30, 1'b0);
        last_good = 8'h29;
        tests_run++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h29) begin tests_failed++; $display("FAIL timeout_next: got %0h want 29", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_glitch();
        clear_obs();
        send_frame(8'h1C, 1'b0, 1'b1, 40, 1'b1);
        last_good = 8'h1C;
        tests_run++; if (got_q.size() != 1) begin tests_failed++; $display("FAIL glitch_count: got %0d want 1", got_q.size()); end
        tests_run++; if (rx_data !== 8'h1C) begin tests_failed++; $display("FAIL glitch_data: got %0h want 1c", rx_data); end
        tests_run++; if (err_seen != 0) begin tests_failed++; $display("FAIL glitch_err: got %0d want 0", err_seen); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h3A, odd_par(8'h3A), 1'b1, 25, 1'b0);
        clear_obs();
        send_bit(1'b0, 25, 1'b0);
        send_bit(1'b1, 25, 1'b0);
        send_bit(1'b0, 25, 1'b0);
        ps2_data = 1'b1;
        cyc(25);
        ps2_clk = 1'b0;
        cyc(15);
        rst_n = 1'b0;
        #1;
        tests_run++; if (rx_data !== 8'h00) begin tests_failed++; $display("FAIL midreset_rx_data: got %0h want 00", rx_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %0b want 0", busy); end
        tests_run++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin tests_failed++; $display("FAIL midreset_pulses: got %0b%0b want 00", rx_valid, frame_err); end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(30);
        tests_run++; if (err_seen != 0 || got_q.size() != 0) begin tests_failed++; $display("FAIL midreset_release: got %0d errs %0d bytes want 0 0", err_seen, got_q.size()); end
        send_frame(8'h77, odd_par(8'h77), 1'b1, 25, 1'b0);
        last_good = 8'h77;
        tests_run++; if (((got_q.size() > 0) ? got_q[0] : 8'hxx) !== 8'h77) begin tests_failed++; $display("FAIL midreset_next: got %0h want 77", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    endtask

    task automatic test_random();
        int exp_err = 0;
        clear_obs();
        exp_q.delete();
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d = 8'($urandom);
            int r = $urandom_range(0, 9);
            bit par = odd_par(d);
            bit stop = 1'b1;
            if (r < 2) par = ~par;
            if (r == 2) stop = 1'b0;
            send_frame(d, par, stop, $urandom_range(20, 50), 1'b0);
            if (frame_ok(d, par, stop)) begin
                exp_q.push_back(d);
                last_good = d;
            end else begin
                exp_err++;
            end
        end
        tests_run++; if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (((got_q.size() > i) ? got_q[i] : 8'hxx) !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL rand_byte%0d: got %0h want %0h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        tests_run++; if (err_seen != exp_err) begin tests_failed++; $display("FAIL rand_err: got %0d want %0d", err_seen, exp_err); end
        tests_run++; if (rx_data !== last_good) begin tests_failed++; $display("FAIL rand_hold: got %0h want %0h", rx_data, last_good); end
        tests_run++; if (both_seen) begin tests_failed++; $display("FAIL exclusive_pulses: got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity_err();
        test_stop_err();
        test_bad_start();
        test_timeout();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
